// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: opcodes, ALU codes, step encodings and strobe bundle for control_sequencer
package ctrl_seq_pkg;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [3:0] ALU_ADD    = 4'b0001;
  localparam logic [3:0] ALU_SUB    = 4'b0010;
  localparam logic [3:0] ALU_AND    = 4'b0011;
  localparam logic [3:0] ALU_OR     = 4'b0100;
  localparam logic [3:0] ALU_PC_INC = 4'b1001;
  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
    T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
    HALTED = 4'd15
  } step_t;
  typedef enum logic [2:0] {
    CL_LD, CL_LDI, CL_ST, CL_RTYPE, CL_ADDI, CL_NOP, CL_HALT, CL_ILL
  } iclass_t;
  typedef struct packed {
    logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, write;
    logic mdr_in, mdr_out, ir_in, y_in, gra, grb, grc, r_in, r_out;
    logic ba_out, c_out, illegal_op;
  } strobes_t;
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction/handshake inputs and datapath strobes of the control sequencer
interface control_sequencer_if #(parameter int ALU_SEL_W = 4);
  logic [31:0] ir;
  logic mem_ready;
  logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in;
  logic read, write, mdr_in, mdr_out, ir_in, y_in;
  logic gra, grb, grc, r_in, r_out, ba_out, c_out;
  logic [ALU_SEL_W-1:0] alu_select;
  logic [3:0] step;
  logic run, illegal_op, mem_err;
  modport master (
    input ir, mem_ready,
    output pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, write, mdr_in, mdr_out, ir_in, y_in,
    output gra, grb, grc, r_in, r_out, ba_out, c_out, alu_select, step, run, illegal_op, mem_err
  );
  modport slave (
    output ir, mem_ready,
    input pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, write, mdr_in, mdr_out, ir_in, y_in,
    input gra, grb, grc, r_in, r_out, ba_out, c_out, alu_select, step, run, illegal_op, mem_err
  );
endinterface

// File: rtl/ctrl_seq_decode.sv
// ctrl_seq_decode: maps an opcode to its instruction class and ALU operation
module ctrl_seq_decode
  import ctrl_seq_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] op,
  output iclass_t             cls,
  output logic [3:0]          alu
);
  always_comb begin
    cls = CL_ILL;
    alu = ALU_ADD;
    case (op)
      OP_LD:   cls = CL_LD;
      OP_LDI:  cls = CL_LDI;
      OP_ST:   cls = CL_ST;
      OP_ADD:  cls = CL_RTYPE;
      OP_SUB:  begin cls = CL_RTYPE; alu = ALU_SUB; end
      OP_AND:  begin cls = CL_RTYPE; alu = ALU_AND; end
      OP_OR:   begin cls = CL_RTYPE; alu = ALU_OR; end
      OP_ADDI: cls = CL_ADDI;
      OP_NOP:  cls = CL_NOP;
      OP_HALT: cls = CL_HALT;
      default: ;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T0..T7 step sequencer with memory wait states (optional timeout: CTRL_SEQ_MEM_TIMEOUT_EN)
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int ALU_SEL_W = 4
`ifdef CTRL_SEQ_MEM_TIMEOUT_EN
  , parameter int MEM_TIMEOUT = 16
`endif
) (
  input logic clk,
  input logic reset_n,
  control_sequencer_if.master bus
);
  step_t step, nxt;
  logic [OPCODE_W-1:0] op_q, ir_op, dec_op;
  iclass_t cls;
  logic [3:0] dec_alu, alu;
  strobes_t s;
  logic ldst, mem_wait, timeout;
  assign ir_op = bus.ir[31:32-OPCODE_W];
  assign dec_op = step == T2 ? ir_op : op_q;
  assign ldst = cls == CL_LD || cls == CL_ST;
  assign mem_wait = step == T1 || (step == T6 && cls == CL_LD) || (step == T7 && cls == CL_ST);
  ctrl_seq_decode #(.OPCODE_W(OPCODE_W)) u_decode (.op(dec_op), .cls(cls), .alu(dec_alu));
`ifdef CTRL_SEQ_MEM_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic mem_err_q;
  assign timeout = mem_wait && !bus.mem_ready && wait_cnt == CW'(MEM_TIMEOUT - 1);
  assign bus.mem_err = mem_err_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      mem_err_q <= 1'b0;
    end else begin
      wait_cnt <= mem_wait && !bus.mem_ready ? wait_cnt + 1'b1 : '0;
      mem_err_q <= mem_err_q || timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign bus.mem_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      step <= T0;
      op_q <= '0;
    end else begin
      step <= nxt;
      if (step == T2) op_q <= ir_op;
    end
  end
  always_comb begin
    nxt = step;
    case (step)
      T0: nxt = T1;
      T1: nxt = bus.mem_ready ? T2 : T1;
      T2: nxt = cls == CL_NOP ? T0 : cls == CL_HALT ? HALTED : T3;
      T3: nxt = cls == CL_ILL ? T0 : T4;
      T4: nxt = T5;
      T5: nxt = ldst ? T6 : T0;
      T6: nxt = cls == CL_ST || bus.mem_ready ? T7 : T6;
      T7: nxt = cls == CL_LD || bus.mem_ready ? T0 : T7;
      default: nxt = HALTED;
    endcase
    if (timeout) nxt = HALTED;
  end
  always_comb begin
    s = '0;
    alu = '0;
    case (step)
      T0: begin s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.z_in = 1'b1; alu = ALU_PC_INC; end
      T1: begin s.zlow_out = 1'b1; s.read = 1'b1; s.mdr_in = 1'b1; s.pc_in = bus.mem_ready; end
      T2: begin s.mdr_out = 1'b1; s.ir_in = 1'b1; end
      T3: begin
        s.illegal_op = cls == CL_ILL;
        s.grb = cls != CL_ILL;
        s.y_in = cls != CL_ILL;
        s.ba_out = ldst || cls == CL_LDI;
        s.r_out = cls == CL_RTYPE || cls == CL_ADDI;
      end
      T4: begin
        s.z_in = 1'b1;
        s.c_out = cls != CL_RTYPE;
        s.grc = cls == CL_RTYPE;
        s.r_out = cls == CL_RTYPE;
        alu = dec_alu;
      end
      T5: begin s.zlow_out = 1'b1; s.mar_in = ldst; s.gra = !ldst; s.r_in = !ldst; end
      T6: begin s.mdr_in = 1'b1; s.read = cls == CL_LD; s.gra = cls == CL_ST; s.r_out = cls == CL_ST; end
      T7: begin s.write = cls == CL_ST; s.mdr_out = cls != CL_ST; s.gra = cls != CL_ST; s.r_in = cls != CL_ST; end
      default: ;
    endcase
  end
  assign {bus.pc_out, bus.mar_in, bus.inc_pc, bus.z_in, bus.zlow_out, bus.pc_in, bus.read, bus.write,
          bus.mdr_in, bus.mdr_out, bus.ir_in, bus.y_in, bus.gra, bus.grb, bus.grc, bus.r_in, bus.r_out,
          bus.ba_out, bus.c_out, bus.illegal_op} = reset_n ? s : '0;
  assign bus.alu_select = reset_n ? ALU_SEL_W'(alu) : '0;
  assign bus.step = step;
  assign bus.run = step != HALTED;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench, expected per-cycle step/strobes queued by the driver and popped at negedge
module tb_control_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  control_sequencer_if #(.ALU_SEL_W(4)) bus ();
`ifdef CTRL_SEQ_MEM_TIMEOUT_EN
  control_sequencer #(.OPCODE_W(5), .ALU_SEL_W(4), .MEM_TIMEOUT(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.master));
`else
  control_sequencer #(.OPCODE_W(5), .ALU_SEL_W(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.master));
`endif
  localparam logic [19:0] PC_OUT = 20'h00001, MAR_IN = 20'h00002, INC_PC = 20'h00004, Z_IN = 20'h00008;
  localparam logic [19:0] ZLOW = 20'h00010, PC_IN = 20'h00020, RD = 20'h00040, WR = 20'h00080;
  localparam logic [19:0] MDR_IN = 20'h00100, MDR_OUT = 20'h00200, IR_IN = 20'h00400, Y_IN = 20'h00800;
  localparam logic [19:0] GRA = 20'h01000, GRB = 20'h02000, GRC = 20'h04000, R_IN = 20'h08000;
  localparam logic [19:0] R_OUT = 20'h10000, BA_OUT = 20'h20000, C_OUT = 20'h40000, ILL = 20'h80000;
  localparam logic [19:0] F0 = PC_OUT | MAR_IN | INC_PC | Z_IN, F1 = ZLOW | RD | MDR_IN, F2 = MDR_OUT | IR_IN;
  localparam logic [31:0] I_LD = 32'h00800055, I_LDX = 32'h00080023, I_NOP = 32'hD0000000, I_HALT = 32'hD8000000;
  typedef struct {
    logic [3:0] st;
    logic [19:0] m;
    logic [3:0] alu;
    logic run;
    logic err;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [19:0] strb;
  logic [4:0] rops [4] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110};
  logic [3:0] ralu [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
  assign strb = {bus.illegal_op, bus.c_out, bus.ba_out, bus.r_out, bus.r_in, bus.grc, bus.grb, bus.gra, bus.y_in,
                 bus.ir_in, bus.mdr_out, bus.mdr_in, bus.write, bus.read, bus.pc_in, bus.zlow_out, bus.z_in,
                 bus.inc_pc, bus.mar_in, bus.pc_out};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      check($sformatf("step@%0d", cyc), 32'(bus.step), 32'(e.st));
      check($sformatf("strobes@%0d", cyc), 32'(strb), 32'(e.m));
      check($sformatf("alu@%0d", cyc), 32'(bus.alu_select), 32'(e.alu));
      check($sformatf("run@%0d", cyc), 32'(bus.run), 32'(e.run));
      check($sformatf("mem_err@%0d", cyc), 32'(bus.mem_err), 32'(e.err));
    end
    cyc++;
  end
  task automatic cy(input logic rn, input logic mr, input logic [3:0] st, input logic [19:0] m,
                    input logic [3:0] alu = 4'h0, input logic run = 1'b1, input logic err = 1'b0);
    reset_n = rn;
    bus.mem_ready = mr;
    q.push_back('{st, m, alu, run, err});
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input int stalls);
    cy(1, 1, 0, F0, 4'h9);
    repeat (stalls) cy(1, 0, 1, F1);
    cy(1, 1, 1, F1 | PC_IN);
    cy(1, 1, 2, F2);
  endtask
  task automatic ld_front(input logic mr);
    cy(1, mr, 3, GRB | BA_OUT | Y_IN);
    cy(1, mr, 4, C_OUT | Z_IN, 4'h1);
    cy(1, mr, 5, ZLOW | MAR_IN);
  endtask
  initial begin
    bus.ir = I_LD;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cy(0, 0, 0, 0);
    fetch(0);
    ld_front(1);
    cy(1, 1, 6, RD | MDR_IN);
    cy(1, 1, 7, MDR_OUT | GRA | R_IN);
    bus.ir = I_LDX;
    fetch(3);
    bus.ir = I_HALT;
    ld_front(0);
    cy(1, 0, 6, RD | MDR_IN);
    cy(1, 0, 6, RD | MDR_IN);
    cy(1, 1, 6, RD | MDR_IN);
    cy(1, 0, 7, MDR_OUT | GRA | R_IN);
    for (int i = 0; i < 4; i++) begin
      bus.ir = {rops[i], 27'h0123456};
      fetch(0);
      cy(1, 1, 3, GRB | R_OUT | Y_IN);
      cy(1, 1, 4, GRC | R_OUT | Z_IN, ralu[i]);
      cy(1, 1, 5, ZLOW | GRA | R_IN);
    end
    bus.ir = 32'h60000005;
    fetch(0);
    cy(1, 1, 3, GRB | R_OUT | Y_IN);
    cy(1, 1, 4, C_OUT | Z_IN, 4'h1);
    cy(1, 1, 5, ZLOW | GRA | R_IN);
    bus.ir = 32'h08000007;
    fetch(0);
    cy(1, 1, 3, GRB | BA_OUT | Y_IN);
    cy(1, 1, 4, C_OUT | Z_IN, 4'h1);
    cy(1, 1, 5, ZLOW | GRA | R_IN);
    bus.ir = 32'h10800010;
    fetch(0);
    ld_front(1);
    cy(1, 0, 6, GRA | R_OUT | MDR_IN);
    cy(1, 0, 7, WR);
    cy(1, 0, 7, WR);
    cy(1, 1, 7, WR);
    bus.ir = I_NOP;
    fetch(0);
    bus.ir = 32'hF8000000;
    fetch(0);
    cy(1, 1, 3, ILL);
    bus.ir = I_LD;
    fetch(0);
    ld_front(1);
    cy(1, 0, 6, RD | MDR_IN);
    cy(0, 0, 6, 0);
    bus.ir = I_NOP;
    fetch(0);
    bus.ir = I_HALT;
    fetch(0);
    repeat (20) cy(1, 1, 15, 0, 4'h0, 0);
    cy(0, 1, 15, 0, 4'h0, 0);
    bus.ir = I_LD;
`ifdef CTRL_SEQ_MEM_TIMEOUT_EN
    cy(1, 0, 0, F0, 4'h9);
    repeat (4) cy(1, 0, 1, F1);
    cy(1, 0, 15, 0, 4'h0, 0, 1);
    cy(0, 0, 15, 0, 4'h0, 0, 1);
    fetch(0);
`else
    cy(1, 0, 0, F0, 4'h9);
    repeat (100) cy(1, 0, 1, F1);
    cy(1, 1, 1, F1 | PC_IN);
    cy(1, 1, 2, F2);
`endif
    ld_front(1);
    cy(1, 1, 6, RD | MDR_IN);
    cy(1, 1, 7, MDR_OUT | GRA | R_IN);
    cy(1, 1, 0, F0, 4'h9);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
